// File: rtl/conv_out_stage_pkg.sv
// Shared constants, the FIFO entry type and the output clamp for the conv output stage.
// Build option: define CONV_OUT_RELU_EN to clamp to 0..127 (ReLU) instead of -128..127.
package conv_pkg;

    localparam int ACC_W   = 21;
    localparam int BIAS_W  = 16;
    localparam int OUT_W   = 8;
    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    last;
    } out_entry_t;

    // Reduce the shifted, rounded value to the output feature range.
    function automatic logic signed [OUT_W-1:0] clampOut(input logic signed [ACC_W+1:0] q);
        logic signed [OUT_W-1:0] res;
`ifdef CONV_OUT_RELU_EN
        if (q[ACC_W+1]) begin
            res = '0;
        end else if (q > (ACC_W+2)'(OUT_MAX)) begin
            res = OUT_W'(OUT_MAX);
        end else begin
            res = q[OUT_W-1:0];
        end
`else
        if (q < (ACC_W+2)'(OUT_MIN)) begin
            res = OUT_W'(OUT_MIN);
        end else if (q > (ACC_W+2)'(OUT_MAX)) begin
            res = OUT_W'(OUT_MAX);
        end else begin
            res = q[OUT_W-1:0];
        end
`endif
        return res;
    endfunction

endpackage

// File: rtl/conv_out_stage_fifo.sv
// Synchronous FIFO with occupancy count. The head is read straight from the array,
// so there is no fall-through; the head reads as zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wrData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdData_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             pushOk;
    logic             popOk;

    // Status flags and accept decisions; a push into a full FIFO only lands when a pop frees a slot.
    always_comb begin
        full_o   = (count_q == (AW+1)'(DEPTH));
        empty_o  = (count_q == '0);
        popOk    = pop_i && !empty_o;
        pushOk   = push_i && (!full_o || popOk);
        rdData_o = empty_o ? '0 : mem_q[rdPtr_q];
        count_o  = count_q;
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popOk) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (pushOk && !popOk) begin
                count_q <= count_q + 1'b1;
            end else if (popOk && !pushOk) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_out_stage.sv
// Conv output stage: bias add, round-half-up right shift, clamp, then a small output FIFO
// with valid/ready and end-of-map marking. CONV_OUT_RELU_EN selects ReLU clamping.
import conv_pkg::*;

module conv_out_stage #(
    parameter int FIFO_DEPTH  = 8,
    parameter int OUT_PER_MAP = 36
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          acc_valid,
    input  logic [ACC_W-1:0]              acc,
    input  logic [BIAS_W-1:0]             bias,
    input  logic [3:0]                    shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PIX_W = $clog2(OUT_PER_MAP);
    localparam int RW    = ACC_W + 2;

    logic signed [ACC_W:0]    s1Sum_q, s1Sum_d;
    logic                     s1Valid_q;
    logic signed [RW-1:0]     roundInc, rounded, shifted;
    logic signed [OUT_W-1:0]  s2Data_q, s2Data_d;
    logic                     s2Valid_q;
    logic [PIX_W-1:0]         pixCnt_q, pixCnt_d;
    logic                     overflow_q, overflow_d;
    logic                     isLast, popOk, pushOk;
    logic                     fifoFull, fifoEmpty;
    out_entry_t               pushEntry, headEntry;
    logic [$bits(out_entry_t)-1:0] headBits;

    // Datapath arithmetic: sign-extended bias add, then round half up, arithmetic shift and clamp.
    always_comb begin
        s1Sum_d  = $signed({acc[ACC_W-1], acc})
                 + $signed({{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias});
        roundInc = '0;
        if (shift != 4'd0) begin
            roundInc = RW'(1) << (shift - 4'd1);
        end
        rounded  = $signed({s1Sum_q[ACC_W], s1Sum_q}) + roundInc;
        shifted  = rounded >>> shift;
        s2Data_d = clampOut(shifted);
    end

    // Two-stage pipeline that never stalls; the valid bits simply follow the input strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Sum_q   <= '0;
            s1Valid_q <= 1'b0;
            s2Data_q  <= '0;
            s2Valid_q <= 1'b0;
        end else begin
            s1Valid_q <= acc_valid;
            s2Valid_q <= s1Valid_q;
            if (acc_valid) begin
                s1Sum_q <= s1Sum_d;
            end
            if (s1Valid_q) begin
                s2Data_q <= s2Data_d;
            end
        end
    end

    // Push decision and map framing; last is taken from the counter at push time so dropped
    // results do not consume a pixel index and back-to-back pushes stay correctly numbered.
    always_comb begin
        popOk          = out_ready && !fifoEmpty;
        pushOk         = s2Valid_q && (!fifoFull || popOk);
        isLast         = (pixCnt_q == PIX_W'(OUT_PER_MAP - 1));
        pushEntry.data = s2Data_q;
        pushEntry.last = isLast;
        pixCnt_d       = pixCnt_q;
        if (pushOk) begin
            pixCnt_d = isLast ? '0 : pixCnt_q + 1'b1;
        end
        overflow_d     = overflow_q || (s2Valid_q && fifoFull && !popOk);
    end

    // Pixel counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pixCnt_q   <= pixCnt_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(out_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (s2Valid_q),
        .wrData_i (pushEntry),
        .pop_i    (out_ready),
        .rdData_o (headBits),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty),
        .count_o  (fifo_count)
    );

    assign headEntry = headBits;
    assign out_valid = !fifoEmpty;
    assign out_data  = headEntry.data;
    assign out_last  = headEntry.last;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_conv_out_stage.sv
// Directed self-checking bench for conv_out_stage. Expected values are hand-computed;
// the clamp expectations follow CONV_OUT_RELU_EN when it is defined for the build.
module tb_conv_out_stage;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               acc_valid = 1'b0;
    logic [20:0]        acc = '0;
    logic [15:0]        bias = '0;
    logic [3:0]         shift = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               out_last;
    logic [3:0]         fifo_count;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    conv_out_stage #(
        .FIFO_DEPTH  (8),
        .OUT_PER_MAP (36)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .acc_valid  (acc_valid),
        .acc        (acc),
        .bias       (bias),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // Advance n clocks, ending 1 unit after the last rising edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle acc_valid pulse carrying the given operands.
    task automatic applyStimulus(input int a, input int b, input int s);
        acc       = 21'(a);
        bias      = 16'(b);
        shift     = 4'(s);
        acc_valid = 1'b1;
        waitCycles(1);
        acc_valid = 1'b0;
    endtask

    // Send one value and sample the output one cycle early and exactly at N+3.
    task automatic runOne(input int a, input int b, input int s,
                          output logic early, output logic vld, output logic signed [7:0] d);
        applyStimulus(a, b, s);
        waitCycles(1);
        early = out_valid;
        waitCycles(1);
        vld = out_valid;
        d   = out_data;
        waitCycles(1);
    endtask

    // Pulse the async reset and return aligned 1 unit after an edge.
    task automatic doReset();
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL reset fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== 8'sd0) begin errors++; $display("[TB] FAIL reset out_data: got %0d expected 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset out_last: got %b expected 0", out_last); end
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
    endtask

    task automatic test_rounding();
        int a[3] = '{100, 37, 5};
        int b[3] = '{0, -5, 0};
        int s[3] = '{3, 1, 1};
        int e[3] = '{13, 16, 3};
        logic early, vld;
        logic signed [7:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runOne(a[i], b[i], s[i], early, vld, d);
            checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL rounding[%0d] early valid: got %b expected 0", i, early); end
            checks++; if (vld !== 1'b1) begin errors++; $display("[TB] FAIL rounding[%0d] valid at N+3: got %b expected 1", i, vld); end
            checks++; if (d !== 8'(e[i])) begin errors++; $display("[TB] FAIL rounding[%0d] data: got %0d expected %0d", i, d, e[i]); end
        end
    endtask

    task automatic test_negative();
        int a[3] = '{-1000, -20, -7};
        int s[3] = '{2, 2, 1};
`ifdef CONV_OUT_RELU_EN
        int e[3] = '{0, 0, 0};
`else
        int e[3] = '{-128, -5, -3};
`endif
        logic early, vld;
        logic signed [7:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runOne(a[i], 0, s[i], early, vld, d);
            checks++; if (vld !== 1'b1) begin errors++; $display("[TB] FAIL negative[%0d] valid: got %b expected 1", i, vld); end
            checks++; if (d !== 8'(e[i])) begin errors++; $display("[TB] FAIL negative[%0d] data: got %0d expected %0d", i, d, e[i]); end
        end
    endtask

    task automatic test_saturation();
        int a[5] = '{20000, 0, 0, 0, 0};
        int b[5] = '{-4000, 127, 128, -128, -129};
        int s[5] = '{4, 0, 0, 0, 0};
`ifdef CONV_OUT_RELU_EN
        int e[5] = '{127, 127, 127, 0, 0};
`else
        int e[5] = '{127, 127, 127, -128, -128};
`endif
        logic early, vld;
        logic signed [7:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            runOne(a[i], b[i], s[i], early, vld, d);
            checks++; if (vld !== 1'b1) begin errors++; $display("[TB] FAIL saturation[%0d] valid: got %b expected 1", i, vld); end
            checks++; if (d !== 8'(e[i])) begin errors++; $display("[TB] FAIL saturation[%0d] data: got %0d expected %0d", i, d, e[i]); end
        end
    endtask

    task automatic test_map_framing();
        int got = 0;
        doReset();
        out_ready = 1'b1;
        bias  = '0;
        shift = '0;
        for (int c = 0; c < 60 && got < 37; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                checks++; if (out_data !== 8'(got)) begin errors++; $display("[TB] FAIL framing[%0d] data: got %0d expected %0d", got, out_data, got); end
                checks++; if (out_last !== (got == 35)) begin errors++; $display("[TB] FAIL framing[%0d] last: got %b expected %b", got, out_last, (got == 35)); end
                got++;
            end
            if (c < 37) begin
                acc       = 21'(c);
                acc_valid = 1'b1;
            end else begin
                acc_valid = 1'b0;
            end
        end
        acc_valid = 1'b0;
        checks++; if (got !== 37) begin errors++; $display("[TB] FAIL framing output count: got %0d expected 37", got); end
        waitCycles(3);
    endtask

    task automatic test_backpressure();
        int got = 0;
        doReset();
        out_ready = 1'b0;
        bias  = '0;
        shift = '0;
        for (int i = 0; i < 10; i++) begin
            acc       = 21'(10 + i);
            acc_valid = 1'b1;
            waitCycles(1);
        end
        acc_valid = 1'b0;
        waitCycles(4);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("[TB] FAIL backpressure count: got %0d expected 8", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL backpressure overflow: got %b expected 1", overflow); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL backpressure valid: got %b expected 1", out_valid); end
        waitCycles(2);
        checks++; if (out_data !== 8'sd10) begin errors++; $display("[TB] FAIL backpressure stable head: got %0d expected 10", out_data); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                checks++; if (out_data !== 8'(10 + got)) begin errors++; $display("[TB] FAIL drain[%0d] data: got %0d expected %0d", got, out_data, 10 + got); end
                got++;
            end
            waitCycles(1);
        end
        out_ready = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("[TB] FAIL drain output count: got %0d expected 8", got); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL drain count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back_full();
        int got = 0;
        int e[8] = '{41, 42, 43, 44, 45, 46, 47, 77};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc       = 21'(40 + i);
            acc_valid = 1'b1;
            waitCycles(1);
        end
        acc_valid = 1'b0;
        waitCycles(4);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("[TB] FAIL refill count: got %0d expected 8", fifo_count); end
        applyStimulus(77, 0, 0);
        waitCycles(1);
        out_ready = 1'b1;
        waitCycles(1);
        out_ready = 1'b0;
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("[TB] FAIL push+pop at full count: got %0d expected 8", fifo_count); end
        checks++; if (out_data !== 8'sd41) begin errors++; $display("[TB] FAIL push+pop at full head: got %0d expected 41", out_data); end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && got < 8) begin
                checks++; if (out_data !== 8'(e[got])) begin errors++; $display("[TB] FAIL full drain[%0d] data: got %0d expected %0d", got, out_data, e[got]); end
                got++;
            end
            waitCycles(1);
        end
        out_ready = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("[TB] FAIL full drain output count: got %0d expected 8", got); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5 + i, 0, 0);
        end
        waitCycles(3);
        checks++; if (fifo_count !== 4'd3) begin errors++; $display("[TB] FAIL pre-reset count: got %0d expected 3", fifo_count); end
        applyStimulus(99, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset out_valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL midreset fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL midreset overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== 8'sd0) begin errors++; $display("[TB] FAIL midreset out_data: got %0d expected 0", out_data); end
        #3;
        rst_n = 1'b1;
        waitCycles(4);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL in-flight discarded valid: got %b expected 0", out_valid); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("[TB] FAIL in-flight discarded count: got %0d expected 0", fifo_count); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_rounding();
        test_negative();
        test_saturation();
        test_map_framing();
        test_backpressure();
        test_back_to_back_full();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_stage.md
Name: conv_out_stage

Overview:
- Downstream neighbour of the conv accumulator. Consumes each finished signed 21-bit `acc` result qualified by a valid strobe.
- Adds a bias, rounds and right-shifts, then applies ReLU/saturation to a signed 8-bit feature.
- Buffers results in a small FIFO with a valid/ready output port. Marks the last pixel of each output map for the next layer or writeback.

Parameters:
- ACC_W, 21, accumulator width from conv
- BIAS_W, 16, signed bias width
- OUT_W, 8, signed output feature width
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)
- OUT_PER_MAP, 36, outputs per map (6x6 result of 8x8 fmap with 3x3 kernel)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- acc_valid  in  1  one-cycle strobe, acc holds a finished result
- acc  in  ACC_W  signed accumulator result
- bias  in  BIAS_W  signed bias; quasi-static during a map
- shift  in  4  right-shift amount 0..15; quasi-static during a map
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  OUT_W  signed feature at FIFO head
- out_last  out  1  head is pixel OUT_PER_MAP-1 of its map
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky; a result was dropped

Behaviour:
- Reset: async on rst_n low. All outputs 0, pipeline valids 0, FIFO empty, pixel counter 0, overflow 0. Reset mid-operation discards in-flight and buffered data.
- S1 stage, registered on the edge after acc_valid:
  - sum = sext(acc) + sext(bias), ACC_W+1 bits.
  - s1_valid = acc_valid.
- S2 stage, registered:
  - r = sum + (shift>0 ? 1<<(shift-1) : 0), ACC_W+2 bits (round half up).
  - q = r >>> shift (arithmetic shift).
  - Clamp q to the output range (see Optional Feature); result is OUT_W bits.
  - last = (pix_cnt == OUT_PER_MAP-1).
  - s2_valid = s1_valid.
- Push: when s2_valid, write {q, last} to the FIFO. On every accepted push, pix_cnt increments and wraps OUT_PER_MAP-1 -> 0.
- Latency: acc_valid high in cycle N gives out_valid high in cycle N+3 when the FIFO was empty. The FIFO has no fall-through bypass.
- Pop: occurs when out_valid && out_ready. out_data and out_last are the registered/array head and stay stable while out_valid && !out_ready.
- Full FIFO:
  - Push while full with no pop in the same cycle: the result is dropped, overflow sets and stays set until reset, and pix_cnt does NOT advance.
  - Push and pop while full: both are accepted and the count is unchanged.
- Empty FIFO: out_ready is ignored and no pop occurs. A push in the same cycle is accepted; out_valid rises the next cycle.
- Back-to-back acc_valid on every cycle is supported at full throughput.
- The pipeline never stalls; only the FIFO absorbs backpressure.
- fifo_count updates on the clock edge: +1 for push, -1 for pop, 0 for both or neither.

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: ReLU. Negative q -> 0; q > 127 -> 127. Output range 0..127.
- Undefined: signed saturation. q < -128 -> -128; q > 127 -> 127.

Decomposition:
- Package conv_pkg:
  - ACC_W, OUT_W, BIAS_W constants.
  - OUT_MAX=127, OUT_MIN=-128.
  - Typedef out_entry_t {logic signed [OUT_W-1:0] data; logic last;}.
- Sub-module: sync_fifo, parameterized width/depth, with push, pop, full, empty and count. It is instantiated once, carrying out_entry_t.

Test Plan:
- Reset state: rst_n=0 mid-stream -> out_valid=0, fifo_count=0, overflow=0 immediately, asynchronously.
- Rounding: acc=100, bias=0, shift=3, out_ready=1 -> out_data=13 at cycle N+3.
- Negative input: acc=-1000, bias=0, shift=2.
  - With RELU_EN -> out_data=0.
  - Without -> out_data=-128 (saturated; raw -250).
- Positive saturation and bias: acc=20000, bias=-4000, shift=4 -> 1000 saturates -> out_data=127.
- Map framing: 36 consecutive acc_valid pulses, out_ready=1 -> 36 outputs; out_last=1 only on the 36th. A 37th input gives out_last=0 (counter wrapped).
- Backpressure and overflow:
  - out_ready=0 with 10 pulses, FIFO_DEPTH=8 -> fifo_count=8 and overflow=1.
  - Then out_ready=1 -> exactly 8 outputs in order, the first 8 inputs.
  - Simultaneous push and pop at full keeps the count at 8.
